multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multi-cycle control unit for the accumulator-style datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM state machine, and generalises instruction width. It adds memory-ready handshakes and tracks the hardware call-stack occupancy, with overflow/underflow faulting. It sits between the instruction register/PC logic and the register file, ALU, data memory and PC stack.

## Interface

Parameters:
- INSTR_WIDTH, 19, instruction width W (≥ 13); opcode fields are taken from the top bits.
- STACK_DEPTH, 8, number of PC-stack entries tracked (≥ 1).
- CW, $clog2(STACK_DEPTH+1), width of stackCount (derived, not overridable).

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- init_signal  in  1  synchronous, active-low reset.
- instr  in  W  instruction memory output.
- imemReady  in  1  instr valid this cycle.
- dmemReady  in  1  data-memory access complete this cycle.
- Zero, CarryOut  in  1 each  registered ALU flags.
- irLoad  out  1  latch instr into internal IR.
- pcWrite  out  1  PC register update enable.
- pcInputSel  out  2  00 adder, 01 jump target, 10 stack top.
- pcAdderInputBSel  out  1  1 = +1, 0 = branch offset.
- ALUfunction  out  4  ALU/shift op.
- AluInputBSel, selectR2  out  1 each  operand muxes.
- LDM  out  1  register-file write enable.
- regFileWriteDataSel  out  1  1 = ALU/shift result, 0 = data memory.
- memRead, STM  out  1 each  data-memory read and write strobes.
- enableZero, enableCarry  out  1 each  flag-register enables.
- push, pop  out  1 each  PC-stack strobes.
- stackCount  out  CW  current stack occupancy.
- stackFull, stackEmpty  out  1 each  stackCount == STACK_DEPTH, stackCount == 0.
- fault  out  1  sticky fault indication.

## Operation

Fields of IR: op2 = IR[W-1:W-2], op3 = IR[W-1:W-3], op5 = IR[W-1:W-5], op6 = IR[W-1:W-6], fn3 = IR[W-3:W-5], fn2 = IR[W-4:W-5].

Instruction classes:
- ALU-reg: op2 = 00. ALUfunction = {1,fn3}, AluInputBSel = 0, selectR2 = 0.
- ALU-imm: op2 = 01. ALUfunction = {1,fn3}, AluInputBSel = 1, selectR2 = 1.
- Shift: op3 = 110. ALUfunction = {00,fn2}; enableCarry only.
- Load: op5 = 10000.
- Store: op5 = 10001; selectR2 = 1.
- Branch: op3 = 101. Taken when fn2 = 00 and Zero = 1, fn2 = 01 and Zero = 0, fn2 = 10 and CarryOut = 1, or fn2 = 11 and CarryOut = 0.
- Jump: op5 = 11100.
- Call: op5 = 11101.
- Return: op6 = 111100.
- Illegal: any other encoding.

States:
- FETCH: irLoad = imemReady. On imemReady, IR ← instr and go to DECODE; otherwise stay.
- DECODE: no strobes. Go to EXEC. If Illegal, go to FAULT instead.
- EXEC:
  - ALU/shift: LDM = 1, regFileWriteDataSel = 1, flag enables as listed (ALU classes: both flags), pcWrite = 1. Go to FETCH.
  - Branch: pcWrite = 1; pcAdderInputBSel = 0 if taken, else 1. Flags are sampled this cycle. Go to FETCH.
  - Jump: pcInputSel = 01, pcWrite = 1. Go to FETCH.
  - Call with !stackFull: push = 1, pcInputSel = 01, pcWrite = 1, stackCount+1. Go to FETCH.
  - Call with stackFull: no strobes. Go to FAULT.
  - Return with !stackEmpty: pop = 1, pcInputSel = 10, pcWrite = 1, stackCount−1. Go to FETCH.
  - Return with stackEmpty: no strobes. Go to FAULT.
  - Load/Store: go to MEM.
- MEM:
  - Load: memRead = 1 every cycle until dmemReady. In the dmemReady cycle also LDM = 1, regFileWriteDataSel = 0, pcWrite = 1, then go to FETCH.
  - Store: STM = 1 every cycle until dmemReady. In the dmemReady cycle also pcWrite = 1, then go to FETCH.
- FAULT: fault = 1 and all strobes 0. Exit only via reset.

Output defaults (any state or case not listed above):
- All outputs are 0, except pcAdderInputBSel = 1.
- ALUfunction and the operand muxes follow the IR in EXEC and MEM, and are 0 elsewhere.

## Timing

- Reset: init_signal low at a rising edge gives state = FETCH, IR = 0, stackCount = 0.
  - While init_signal is low, all outputs are forced to defaults: stackEmpty = 1, stackFull = 0, fault = 0, pcAdderInputBSel = 1.
  - Reset mid-MEM aborts the access at that edge. No LDM or pcWrite is issued.
- All outputs are combinational from state, IR, the flags and the ready inputs.
- Latency with ready already asserted:
  - ALU, shift, branch, jump, call, return: 3 cycles (FETCH, DECODE, EXEC).
  - Load, store: 4 cycles (FETCH, DECODE, EXEC, MEM).
  - Each cycle of ready held low adds one cycle.
- push and pop are single-cycle and never asserted together. stackCount changes on the edge ending EXEC.
- STACK_DEPTH = 1: a call makes the stack full, and the next call faults.

## Test plan

- Reset, then ALU-reg op2 = 00, fn3 = 010 with imemReady held 1 → irLoad in cycle 0. EXEC in cycle 2 shows ALUfunction = 1010, LDM = 1, enableZero = enableCarry = 1, pcWrite = 1. Back in FETCH at cycle 3.
- BZ (fn2 = 00): with Zero = 1 → pcAdderInputBSel = 0 in EXEC. With Zero = 0 → pcAdderInputBSel = 1. Repeat for BNC with CarryOut = 0 → taken.
- Load with dmemReady low for 3 MEM cycles → memRead held 4 cycles. LDM = 1 and regFileWriteDataSel = 0 only in the ready cycle. Total of 7 cycles.
- STACK_DEPTH = 2: call, call, call → stackCount goes 1, 2, stackFull = 1. The third call produces no push, fault = 1, and the controller stays in FAULT under further instructions.
- Return with stackCount = 0 → no pop, fault = 1. Then pulse init_signal low for one edge → fault = 0, stackEmpty = 1, FETCH resumes.
- Illegal op6 = 111110 → FAULT directly after DECODE. Separately, reset asserted during a store's MEM wait → STM drops immediately and no pcWrite is issued.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Bundles the control unit's bus: instruction/memory handshakes and flags in,
// datapath strobes and stack status out.
interface multicycle_controller_if #(
  parameter int INSTR_WIDTH = 19,
  parameter int STACK_DEPTH = 8
);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [INSTR_WIDTH-1:0] instr;
  logic                   imemReady;
  logic                   dmemReady;
  logic                   Zero;
  logic                   CarryOut;

  logic                   irLoad;
  logic                   pcWrite;
  logic [1:0]             pcInputSel;
  logic                   pcAdderInputBSel;
  logic [3:0]             ALUfunction;
  logic                   AluInputBSel;
  logic                   selectR2;
  logic                   LDM;
  logic                   regFileWriteDataSel;
  logic                   memRead;
  logic                   STM;
  logic                   enableZero;
  logic                   enableCarry;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          stackCount;
  logic                   stackFull;
  logic                   stackEmpty;
  logic                   fault;

  modport master (
    input  instr, imemReady, dmemReady, Zero, CarryOut,
    output irLoad, pcWrite, pcInputSel, pcAdderInputBSel, ALUfunction,
           AluInputBSel, selectR2, LDM, regFileWriteDataSel, memRead, STM,
           enableZero, enableCarry, push, pop, stackCount, stackFull,
           stackEmpty, fault
  );

  modport slave (
    output instr, imemReady, dmemReady, Zero, CarryOut,
    input  irLoad, pcWrite, pcInputSel, pcAdderInputBSel, ALUfunction,
           AluInputBSel, selectR2, LDM, regFileWriteDataSel, memRead, STM,
           enableZero, enableCarry, push, pop, stackCount, stackFull,
           stackEmpty, fault
  );
endinterface

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM control unit with memory-ready handshakes and a
// tracked PC-stack occupancy that faults on overflow/underflow.
module multicycle_controller #(
  parameter int INSTR_WIDTH = 19,
  parameter int STACK_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    init_signal,
  multicycle_controller_if.master bus
);
  localparam int W  = INSTR_WIDTH;
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_FAULT} state_t;

  state_t        r_state;
  // Only the six opcode bits steer control; operand bits live in the datapath IR.
  logic [5:0]    r_ir;
  logic [CW-1:0] r_stack_count;

  logic w_is_alu_reg, w_is_alu_imm, w_is_alu, w_is_shift, w_is_load, w_is_store;
  logic w_is_branch, w_is_jump, w_is_call, w_is_ret, w_is_illegal, w_taken;
  logic w_full, w_empty;
  logic [1:0] w_fn2;

  assign w_fn2        = r_ir[2:1];
  assign w_is_alu_reg = (r_ir[5:4] == 2'b00);
  assign w_is_alu_imm = (r_ir[5:4] == 2'b01);
  assign w_is_alu     = w_is_alu_reg | w_is_alu_imm;
  assign w_is_shift   = (r_ir[5:3] == 3'b110);
  assign w_is_branch  = (r_ir[5:3] == 3'b101);
  assign w_is_load    = (r_ir[5:1] == 5'b10000);
  assign w_is_store   = (r_ir[5:1] == 5'b10001);
  assign w_is_jump    = (r_ir[5:1] == 5'b11100);
  assign w_is_call    = (r_ir[5:1] == 5'b11101);
  assign w_is_ret     = (r_ir == 6'b111100);
  assign w_is_illegal = ~(w_is_alu | w_is_shift | w_is_branch | w_is_load |
                          w_is_store | w_is_jump | w_is_call | w_is_ret);
  assign w_full       = (r_stack_count == DEPTH_C);
  assign w_empty      = (r_stack_count == '0);

  always_comb begin
    case (w_fn2)
      2'b00:   w_taken = bus.Zero;
      2'b01:   w_taken = ~bus.Zero;
      2'b10:   w_taken = bus.CarryOut;
      default: w_taken = ~bus.CarryOut;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!init_signal) begin
      r_state       <= S_FETCH;
      r_ir          <= '0;
      r_stack_count <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (bus.imemReady) begin
          r_ir    <= bus.instr[W-1:W-6];
          r_state <= S_DECODE;
        end
        S_DECODE: r_state <= w_is_illegal ? S_FAULT : S_EXEC;
        S_EXEC: begin
          if (w_is_load || w_is_store) begin
            r_state <= S_MEM;
          end else if (w_is_call) begin
            if (w_full) r_state <= S_FAULT;
            else begin
              r_stack_count <= r_stack_count + 1'b1;
              r_state       <= S_FETCH;
            end
          end else if (w_is_ret) begin
            if (w_empty) r_state <= S_FAULT;
            else begin
              r_stack_count <= r_stack_count - 1'b1;
              r_state       <= S_FETCH;
            end
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM:   if (bus.dmemReady) r_state <= S_FETCH;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are combinational and collapse to defaults while reset is held.
  always_comb begin
    bus.irLoad              = 1'b0;
    bus.pcWrite             = 1'b0;
    bus.pcInputSel          = 2'b00;
    bus.pcAdderInputBSel    = 1'b1;
    bus.ALUfunction         = 4'b0000;
    bus.AluInputBSel        = 1'b0;
    bus.selectR2            = 1'b0;
    bus.LDM                 = 1'b0;
    bus.regFileWriteDataSel = 1'b0;
    bus.memRead             = 1'b0;
    bus.STM                 = 1'b0;
    bus.enableZero          = 1'b0;
    bus.enableCarry         = 1'b0;
    bus.push                = 1'b0;
    bus.pop                 = 1'b0;
    bus.fault               = 1'b0;
    bus.stackCount          = '0;
    bus.stackFull           = 1'b0;
    bus.stackEmpty          = 1'b1;
    if (init_signal) begin
      bus.stackCount = r_stack_count;
      bus.stackFull  = w_full;
      bus.stackEmpty = w_empty;
      if (r_state == S_EXEC || r_state == S_MEM) begin
        if (w_is_alu)   bus.ALUfunction = {1'b1, r_ir[3:1]};
        if (w_is_shift) bus.ALUfunction = {2'b00, w_fn2};
        bus.AluInputBSel = w_is_alu_imm;
        bus.selectR2     = w_is_alu_imm | w_is_store;
      end
      case (r_state)
        S_FETCH: bus.irLoad = bus.imemReady;
        S_EXEC: begin
          if (w_is_alu || w_is_shift) begin
            bus.LDM                 = 1'b1;
            bus.regFileWriteDataSel = 1'b1;
            bus.enableZero          = w_is_alu;
            bus.enableCarry         = 1'b1;
            bus.pcWrite             = 1'b1;
          end else if (w_is_branch) begin
            bus.pcWrite          = 1'b1;
            bus.pcAdderInputBSel = ~w_taken;
          end else if (w_is_jump) begin
            bus.pcInputSel = 2'b01;
            bus.pcWrite    = 1'b1;
          end else if (w_is_call && !w_full) begin
            bus.push       = 1'b1;
            bus.pcInputSel = 2'b01;
            bus.pcWrite    = 1'b1;
          end else if (w_is_ret && !w_empty) begin
            bus.pop        = 1'b1;
            bus.pcInputSel = 2'b10;
            bus.pcWrite    = 1'b1;
          end
        end
        S_MEM: begin
          bus.memRead = w_is_load;
          bus.STM     = w_is_store;
          if (bus.dmemReady) begin
            bus.LDM     = w_is_load;
            bus.pcWrite = 1'b1;
          end
        end
        S_FAULT: bus.fault = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (W=19, STACK_DEPTH=2): one line per
// check, hand-computed expectations.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rstn;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.INSTR_WIDTH(19), .STACK_DEPTH(2)) bus ();
  multicycle_controller #(.INSTR_WIDTH(19), .STACK_DEPTH(2)) dut (
    .clock       (clk),
    .init_signal (rstn),
    .bus         (bus)
  );

  function automatic logic [18:0] mk(input logic [5:0] top);
    return {top, 13'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) begin
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH + DECODE for one instruction; returns settled in the following cycle.
  task automatic to_exec(input logic [5:0] top);
    bus.instr     = mk(top);
    bus.imemReady = 1'b1;
    #1;
    chk("fetch_irLoad", 32'(bus.irLoad), 32'd1);
    tick();
    bus.imemReady = 1'b0;
    #1;
    chk("decode_quiet", {bus.irLoad, bus.pcWrite, bus.LDM, bus.pcAdderInputBSel}, 32'b0001);
    tick();
    #1;
  endtask

  initial begin
    rstn          = 1'b0;
    bus.instr     = '0;
    bus.imemReady = 1'b0;
    bus.dmemReady = 1'b0;
    bus.Zero      = 1'b0;
    bus.CarryOut  = 1'b0;
    tick();
    tick();
    bus.imemReady = 1'b1;
    #1;
    chk("rst_irLoad", 32'(bus.irLoad), 32'd0);
    chk("rst_status", {bus.stackEmpty, bus.stackFull, bus.fault, bus.pcAdderInputBSel}, 32'b1001);
    chk("rst_count", 32'(bus.stackCount), 32'd0);
    bus.imemReady = 1'b0;
    rstn = 1'b1;
    #1;

    // ALU-reg fn3=010
    to_exec(6'b000100);
    chk("alu_fn", 32'(bus.ALUfunction), 32'b1010);
    chk("alu_strobes", {bus.LDM, bus.regFileWriteDataSel, bus.enableZero, bus.enableCarry, bus.pcWrite}, 32'b11111);
    chk("alu_mux", {bus.AluInputBSel, bus.selectR2}, 32'b00);
    tick();
    bus.imemReady = 1'b0;
    #1;
    chk("alu_back_idle", {bus.irLoad, bus.pcWrite}, 32'b00);

    // ALU-imm fn3=011
    to_exec(6'b010110);
    chk("imm_fn", 32'(bus.ALUfunction), 32'b1011);
    chk("imm_mux", {bus.AluInputBSel, bus.selectR2}, 32'b11);
    tick();

    // Shift fn2=01
    to_exec(6'b110010);
    chk("shf_fn", 32'(bus.ALUfunction), 32'b0001);
    chk("shf_flags", {bus.enableZero, bus.enableCarry, bus.LDM}, 32'b011);
    tick();

    // Branches
    bus.Zero = 1'b1;
    to_exec(6'b101000);
    chk("bz_taken", {bus.pcWrite, bus.pcAdderInputBSel}, 32'b10);
    tick();
    bus.Zero = 1'b0;
    to_exec(6'b101000);
    chk("bz_not_taken", {bus.pcWrite, bus.pcAdderInputBSel}, 32'b11);
    tick();
    bus.CarryOut = 1'b0;
    to_exec(6'b101110);
    chk("bnc_taken", 32'(bus.pcAdderInputBSel), 32'd0);
    tick();
    bus.CarryOut = 1'b1;
    to_exec(6'b101100);
    chk("bc_taken", 32'(bus.pcAdderInputBSel), 32'd0);
    tick();

    // Jump
    to_exec(6'b111000);
    chk("jmp", {bus.pcInputSel, bus.pcWrite, bus.push}, 32'b0110);
    tick();

    // Load with 3 wait cycles
    to_exec(6'b100000);
    chk("ld_exec", {bus.memRead, bus.pcWrite, bus.LDM}, 32'b000);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.dmemReady = 1'b0;
      #1;
      chk("ld_wait", {bus.memRead, bus.LDM, bus.pcWrite}, 32'b100);
      tick();
    end
    bus.dmemReady = 1'b1;
    #1;
    chk("ld_ready", {bus.memRead, bus.LDM, bus.regFileWriteDataSel, bus.pcWrite}, 32'b1101);
    tick();
    bus.dmemReady = 1'b0;
    bus.imemReady = 1'b1;
    #1;
    chk("ld_refetch", {bus.irLoad, bus.memRead}, 32'b10);

    // Store, ready immediately
    to_exec(6'b100010);
    tick();
    bus.dmemReady = 1'b1;
    #1;
    chk("st_ready", {bus.STM, bus.selectR2, bus.pcWrite, bus.LDM}, 32'b1110);
    tick();
    bus.dmemReady = 1'b0;

    // Stack: call, call, return, call, call(overflow)
    to_exec(6'b111010);
    chk("call1", {bus.push, bus.pop, bus.pcInputSel, bus.pcWrite}, 32'b10011);
    tick();
    chk("cnt1", 32'(bus.stackCount), 32'd1);
    to_exec(6'b111010);
    chk("call2_push", 32'(bus.push), 32'd1);
    tick();
    chk("cnt2_full", {30'(bus.stackCount), bus.stackFull, bus.stackEmpty}, {30'd2, 2'b10});
    to_exec(6'b111100);
    chk("ret_pop", {bus.push, bus.pop, bus.pcInputSel, bus.pcWrite}, 32'b01101);
    tick();
    chk("cnt_after_ret", 32'(bus.stackCount), 32'd1);
    to_exec(6'b111010);
    tick();
    chk("cnt2_again", 32'(bus.stackFull), 32'd1);
    to_exec(6'b111010);
    chk("call3_nopush", {bus.push, bus.pcWrite}, 32'b00);
    tick();
    chk("call3_fault", 32'(bus.fault), 32'd1);
    bus.instr     = mk(6'b000100);
    bus.imemReady = 1'b1;
    tick();
    tick();
    chk("fault_sticky", {bus.fault, bus.irLoad, bus.LDM, bus.pcWrite}, 32'b1000);
    bus.imemReady = 1'b0;

    rstn = 1'b0;
    #1;
    chk("rst_forced", {bus.fault, bus.stackEmpty, bus.stackFull}, 32'b010);
    tick();
    rstn = 1'b1;
    #1;

    // Return on empty stack
    to_exec(6'b111100);
    chk("ret_empty", {bus.pop, bus.pcWrite}, 32'b00);
    tick();
    chk("ret_fault", 32'(bus.fault), 32'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.imemReady = 1'b1;
    #1;
    chk("recover", {bus.fault, bus.stackEmpty, bus.irLoad}, 32'b011);
    bus.imemReady = 1'b0;
    #1;

    // Illegal opcode
    to_exec(6'b111110);
    chk("illegal_fault", {bus.fault, bus.pcWrite}, 32'b10);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;

    // Reset during store MEM wait
    to_exec(6'b100010);
    tick();
    bus.dmemReady = 1'b0;
    #1;
    chk("st_wait", {bus.STM, bus.pcWrite}, 32'b10);
    rstn = 1'b0;
    #1;
    chk("st_rst_drop", {bus.STM, bus.pcWrite}, 32'b00);
    tick();
    rstn = 1'b1;
    bus.dmemReady = 1'b1;
    #1;
    chk("st_aborted", {bus.STM, bus.pcWrite, bus.LDM}, 32'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
